// File: rtl/spi_master_reader_pkg.sv
// rtl/spi_master_reader_pkg.sv - shared state encoding and framing constants for the SPI reader
package spi_master_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam logic [7:0] DUMMY_BYTE = 8'h00;
  // The slave-side FSM counts the same number of address bytes before serving data.
  localparam logic [1:0] ADDR_BYTES = 2'd2;

  function automatic logic [7:0] addr_byte(input logic [15:0] addr, input logic [1:0] idx);
    return (idx == 2'd0) ? addr[15:8] : addr[7:0];
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - SCK divider and 8-bit MSB-first shift/sample engine for one SPI byte
module spi_master_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_tx_byte,
  input  logic       i_miso,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_rx_last,
  output logic [7:0] o_rx_byte,
  output logic       o_sck,
  output logic       o_mosi
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] tx_q;
  logic [6:0] rx_q;
  logic       busy_q;
  logic       sck_q;
  logic       mosi_q;
  logic       done_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q  <= 8'd0;
      bit_q  <= 3'd0;
      tx_q   <= 8'd0;
      rx_q   <= 7'd0;
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (i_load) begin
          busy_q <= 1'b1;
          tx_q   <= i_tx_byte;
          mosi_q <= i_tx_byte[7];
          div_q  <= 8'd0;
          bit_q  <= 3'd0;
          sck_q  <= 1'b0;
        end
      end else if (div_q != DIV_LAST) begin
        div_q <= div_q + 8'd1;
      end else begin
        div_q <= 8'd0;
        if (!sck_q) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[5:0], i_miso};
        end else begin
          sck_q <= 1'b0;
          if (bit_q == 3'd7) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            mosi_q <= 1'b0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            tx_q   <= {tx_q[6:0], 1'b0};
            mosi_q <= tx_q[6];
          end
        end
      end
    end
  end

  // High on the edge that takes the 8th sample; o_rx_byte then holds the whole byte.
  assign o_rx_last = (div_q == DIV_LAST) && !sck_q && (bit_q == 3'd7);
  assign o_rx_byte = {rx_q, i_miso};
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_sck     = sck_q;
  assign o_mosi    = mosi_q;

endmodule

// File: rtl/spi_master_reader.sv
// rtl/spi_master_reader.sv - SPI mode-0 master: sends 16-bit address, reads N bytes under one CS
// Optional inter-byte idle gap enabled by defining SPI_GAP_EN.
module spi_master_reader #(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int GAP_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        o_busy,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_valid,
  output logic        o_done,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_cs,
  input  logic        i_miso
);

  import spi_master_reader_pkg::*;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
`ifdef SPI_GAP_EN
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
`endif

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be within 2..255");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || GAP_CYCLES < 1) begin : g_bad_timing
    $error("CS_SETUP, CS_HOLD and GAP_CYCLES must be at least 1");
  end

  state_e      state_q;
  logic [15:0] addr_q;
  logic [7:0]  rem_q;
  logic [1:0]  hdr_q;
  logic        data_q;
  logic [7:0]  cnt_q;
  logic        busy_q;
  logic        cs_q;
  logic        done_q;
  logic        rx_valid_q;
  logic [7:0]  rx_byte_q;
  logic        load_q;
  logic [7:0]  tx_byte_q;

  logic        sh_busy;
  logic        sh_done;
  logic        sh_rx_last;
  logic [7:0]  sh_rx_byte;
  logic        sh_sck;
  logic        sh_mosi;

  logic        next_is_data;
  logic [7:0]  next_byte;
  logic        more_bytes;
  logic        issue;

  assign next_is_data = (hdr_q >= ADDR_BYTES);
  assign next_byte    = next_is_data ? DUMMY_BYTE : addr_byte(addr_q, hdr_q);
  assign more_bytes   = !next_is_data || (rem_q != 8'd0);

  // Cycle in which the next byte is handed to the shifter.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      ST_SETUP: issue = (cnt_q == SETUP_LAST);
`ifdef SPI_GAP_EN
      ST_GAP:   issue = (cnt_q == GAP_LAST);
`else
      ST_SHIFT: issue = sh_done && more_bytes;
`endif
      default:  issue = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 16'd0;
      rem_q      <= 8'd0;
      hdr_q      <= 2'd0;
      data_q     <= 1'b0;
      cnt_q      <= 8'd0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      load_q     <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      load_q     <= 1'b0;

      if (issue) begin
        load_q    <= 1'b1;
        tx_byte_q <= next_byte;
        data_q    <= next_is_data;
        if (next_is_data) rem_q <= rem_q - 8'd1;
        else              hdr_q <= hdr_q + 2'd1;
      end

      if (sh_busy && sh_rx_last && data_q) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= sh_rx_byte;
      end

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            addr_q  <= i_addr;
            rem_q   <= i_len;
            hdr_q   <= 2'd0;
            data_q  <= 1'b0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (issue) state_q <= ST_SHIFT;
          else       cnt_q   <= cnt_q + 8'd1;
        end
        ST_SHIFT: begin
          if (sh_done) begin
            if (!more_bytes) begin
              cnt_q   <= 8'd0;
              state_q <= ST_HOLD;
            end
`ifdef SPI_GAP_EN
            else begin
              cnt_q   <= 8'd0;
              state_q <= ST_GAP;
            end
`endif
          end
        end
`ifdef SPI_GAP_EN
        ST_GAP: begin
          if (issue) state_q <= ST_SHIFT;
          else       cnt_q   <= cnt_q + 8'd1;
        end
`endif
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cs_q    <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spi_master_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (load_q),
    .i_tx_byte (tx_byte_q),
    .i_miso    (i_miso),
    .o_busy    (sh_busy),
    .o_done    (sh_done),
    .o_rx_last (sh_rx_last),
    .o_rx_byte (sh_rx_byte),
    .o_sck     (sh_sck),
    .o_mosi    (sh_mosi)
  );

  // During SETUP the first address bit is presented before the shifter is loaded.
  assign o_mosi     = (state_q == ST_SETUP) ? addr_q[15] : sh_mosi;
  assign o_sck      = sh_sck;
  assign o_cs       = cs_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_byte  = rx_byte_q;

endmodule

// File: tb/tb_spi_master_reader.sv
// tb/tb_spi_master_reader.sv - self-checking bench for spi_master_reader with an SPI slave model
module tb_spi_master_reader;

`ifdef SPI_GAP_EN
  localparam int CLK_DIV = 2;
`else
  localparam int CLK_DIV = 4;
`endif
  localparam int GAP_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [7:0]  len = 8'd0;
  logic        miso = 1'b0;
  logic        busy, rx_valid, done, sck, mosi, cs;
  logic [7:0]  rx_byte;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_master_reader #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(2), .CS_HOLD(2), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_addr(addr), .i_len(len),
    .o_busy(busy), .o_rx_byte(rx_byte), .o_rx_valid(rx_valid), .o_done(done),
    .o_sck(sck), .o_mosi(mosi), .o_cs(cs), .i_miso(miso)
  );

  // Slave model: shifts out slv_bytes MSB-first, changing MISO after each SCK rise.
  logic [7:0] slv_bytes [0:259];
  logic [7:0] mosi_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] mosi_sr = 8'd0;
  logic       prev_sck = 1'b0;
  logic       prev_cs = 1'b1;
  int rise_cnt = 0, done_cnt = 0, cs_rise_err = 0;
  int low_run = 0, gap_min = 1000000, gap_max = 0;

  function automatic logic slv_bit(input int n);
    logic [7:0] b;
    b = slv_bytes[(n / 8) % 260];
    return b[7 - (n % 8)];
  endfunction

  function automatic logic [7:0] exp_mosi(input logic [15:0] a, input int idx);
    if (idx == 0) return a[15:8];
    if (idx == 1) return a[7:0];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (cs && sck && !prev_sck) cs_rise_err++;
    if (!cs && prev_cs) begin
      rise_cnt = 0;
      miso = slv_bit(0);
      low_run = 0;
    end
    if (!cs && sck && !prev_sck) begin
      if (rise_cnt > 0 && rise_cnt % 8 == 0) begin
        if (low_run < gap_min) gap_min = low_run;
        if (low_run > gap_max) gap_max = low_run;
      end
      mosi_sr = {mosi_sr[6:0], mosi};
      rise_cnt++;
      if (rise_cnt % 8 == 0) mosi_q.push_back(mosi_sr);
      miso = slv_bit(rise_cnt);
      low_run = 0;
    end else if (!cs && !sck) begin
      low_run++;
    end
    if (rx_valid) rx_q.push_back(rx_byte);
    if (done) done_cnt++;
    prev_sck = sck;
    prev_cs = cs;
  end

  task automatic clear_mon();
    mosi_q.delete();
    rx_q.delete();
    rise_cnt = 0;
    done_cnt = 0;
    cs_rise_err = 0;
    gap_min = 1000000;
    gap_max = 0;
  endtask

  task automatic fill_slave();
    for (int i = 0; i < 260; i++) slv_bytes[i] = 8'($urandom);
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    addr = a; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int l, output bit timed_out);
    int budget;
    budget = (2 + l) * (16 * CLK_DIV + GAP_CYCLES + 8) + 100;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({cs, sck, mosi, busy, rx_valid, done, rx_byte} !== {6'b100000, 8'h00}) begin
      err_cnt++;
      $display("FAIL reset_outputs: got cs=%b sck=%b mosi=%b busy=%b rxv=%b done=%b rx=%h, want 1 0 0 0 0 0 00",
               cs, sck, mosi, busy, rx_valid, done, rx_byte);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (cs !== 1'b1 || sck !== 1'b0) bad++;
    end
    cmp_cnt++;
    if (bad != 0 || rx_q.size() != 0 || done_cnt != 0) begin
      err_cnt++;
      $display("FAIL idle_quiet: got bad_cycles=%0d rx=%0d done=%0d, want 0 0 0", bad, rx_q.size(), done_cnt);
    end
  endtask

  task automatic test_transaction(input logic [15:0] a, input logic [7:0] l, input bit keep_slave);
    bit to;
    int bad_mosi, bad_rx;
    if (!keep_slave) fill_slave();
    clear_mon();
    pulse_start(a, l);
    wait_done(int'(l), to);
    cmp_cnt++;
    if (to) begin
      err_cnt++;
      $display("FAIL txn_timeout: addr=%h len=%0d got no o_done, want o_done", a, l);
    end
    cmp_cnt++;
    if (mosi_q.size() != 2 + int'(l)) begin
      err_cnt++;
      $display("FAIL mosi_count: addr=%h len=%0d got %0d bytes, want %0d", a, l, mosi_q.size(), 2 + int'(l));
    end
    bad_mosi = 0;
    for (int i = 0; i < mosi_q.size(); i++)
      if (mosi_q[i] !== exp_mosi(a, i)) bad_mosi++;
    cmp_cnt++;
    if (bad_mosi != 0) begin
      err_cnt++;
      $display("FAIL mosi_bytes: addr=%h len=%0d got %0d wrong bytes (first %h), want %h %h then 00",
               a, l, bad_mosi, mosi_q.size() > 0 ? mosi_q[0] : 8'hxx, a[15:8], a[7:0]);
    end
    cmp_cnt++;
    if (rx_q.size() != int'(l)) begin
      err_cnt++;
      $display("FAIL rx_count: addr=%h len=%0d got %0d strobes, want %0d", a, l, rx_q.size(), l);
    end
    bad_rx = 0;
    for (int i = 0; i < rx_q.size() && i < int'(l); i++)
      if (rx_q[i] !== slv_bytes[2 + i]) bad_rx++;
    cmp_cnt++;
    if (bad_rx != 0) begin
      err_cnt++;
      $display("FAIL rx_bytes: addr=%h len=%0d got %0d wrong data bytes, want 0", a, l, bad_rx);
    end
    cmp_cnt++;
    if (rise_cnt != 8 * (2 + int'(l))) begin
      err_cnt++;
      $display("FAIL sck_pulses: len=%0d got %0d, want %0d", l, rise_cnt, 8 * (2 + int'(l)));
    end
    cmp_cnt++;
    if (done_cnt != 1 || cs !== 1'b1 || busy !== 1'b0 || cs_rise_err != 0) begin
      err_cnt++;
      $display("FAIL txn_end: got done=%0d cs=%b busy=%b sck_while_cs_high=%0d, want 1 1 0 0",
               done_cnt, cs, busy, cs_rise_err);
    end
    cmp_cnt++;
`ifdef SPI_GAP_EN
    if (gap_min < GAP_CYCLES) begin
      err_cnt++;
      $display("FAIL byte_gap: got min idle %0d cycles, want >= %0d", gap_min, GAP_CYCLES);
    end
`else
    if (gap_max > CLK_DIV + 3) begin
      err_cnt++;
      $display("FAIL byte_gap: got max low run %0d cycles, want <= %0d", gap_max, CLK_DIV + 3);
    end
`endif
  endtask

  task automatic test_directed();
    fill_slave();
    slv_bytes[2] = 8'h11;
    slv_bytes[3] = 8'h22;
    slv_bytes[4] = 8'h33;
    test_transaction(16'hA55A, 8'd3, 1'b1);
  endtask

  task automatic test_len0();
    test_transaction(16'h8000, 8'd0, 1'b0);
  endtask

  task automatic test_ignore_start();
    bit to;
    logic [15:0] a;
    int guard;
    a = 16'($urandom);
    fill_slave();
    clear_mon();
    pulse_start(a, 8'd2);
    guard = 0;
    while (rise_cnt < 12 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    pulse_start(16'h1234, 8'd7);
    wait_done(2, to);
    repeat (60) @(posedge clk);
    #1;
    cmp_cnt++;
    if (to || mosi_q.size() != 4 || rise_cnt != 32 || rx_q.size() != 2 || done_cnt != 1) begin
      err_cnt++;
      $display("FAIL ignore_start_shape: got timeout=%0d bytes=%0d pulses=%0d rx=%0d done=%0d, want 0 4 32 2 1",
               to, mosi_q.size(), rise_cnt, rx_q.size(), done_cnt);
    end
    cmp_cnt++;
    if (mosi_q.size() >= 2 && (mosi_q[0] !== a[15:8] || mosi_q[1] !== a[7:0])) begin
      err_cnt++;
      $display("FAIL ignore_start_addr: got %h%h, want %h", mosi_q[0], mosi_q[1], a);
    end
    cmp_cnt++;
    if (cs !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL ignore_start_idle: got cs=%b busy=%b, want 1 0", cs, busy);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    fill_slave();
    clear_mon();
    pulse_start(16'($urandom), 8'd4);
    guard = 0;
    while (rise_cnt < 27 && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    cmp_cnt++;
    if (rise_cnt < 27) begin
      err_cnt++;
      $display("FAIL reset_mid_reach: got %0d SCK pulses, want >= 27", rise_cnt);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if (cs !== 1'b1 || sck !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_immediate: got cs=%b sck=%b, want 1 0", cs, sck);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    cmp_cnt++;
    if (done_cnt != 0 || rx_q.size() != 1 || busy !== 1'b0 || cs !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_mid_abort: got done=%0d rx=%0d busy=%b cs=%b, want 0 1 0 1",
               done_cnt, rx_q.size(), busy, cs);
    end
    test_transaction(16'($urandom), 8'd1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      test_transaction(16'($urandom), 8'($urandom_range(0, 20)), 1'b0);
  endtask

  task automatic test_len255();
    test_transaction(16'($urandom), 8'd255, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_len0();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_len255();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spi_master_reader.md
Name: spi_master_reader

Overview:
- Host-side SPI master that drives the memory-test FPGA's SPI slave port.
- Per transaction: asserts CS, shifts out a 16-bit memory address MSB-first, then clocks N dummy bytes to read back N data bytes, then releases CS.
- Used in the bench-side harness and in the loopback test FPGA to exercise memory banks and the signature region end-to-end.

Parameters:
- CLK_DIV, 4, i_clk cycles per SCK half-period; legal range 2..255.
- CS_SETUP, 2, i_clk cycles between CS falling and the first SCK rising edge.
- CS_HOLD, 2, i_clk cycles between the last SCK falling edge and CS rising.
- GAP_CYCLES, 8, idle i_clk cycles between bytes, with CS held low. Only used when SPI_GAP_EN is defined.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle request; sampled only in IDLE
- i_addr  in  16  target address; latched on accepted i_start
- i_len  in  8  number of data bytes to read (0..255); latched on accepted i_start
- o_busy  out  1  high from the accepted start until o_done
- o_rx_byte  out  8  received data byte
- o_rx_valid  out  1  one-cycle strobe; o_rx_byte is valid in that cycle
- o_done  out  1  one-cycle pulse at transaction end
- o_sck  out  1  SPI clock, mode 0 (idle low)
- o_mosi  out  1  master out
- o_cs  out  1  chip select, active-low
- i_miso  in  1  master in; already synchronised externally

Behaviour:
- Reset (asynchronous, immediate):
  - o_cs=1, o_sck=0, o_mosi=0.
  - o_busy=0, o_rx_valid=0, o_done=0, o_rx_byte=8'h00.
  - FSM goes to IDLE.
  - A reset mid-transaction aborts it: no o_done, no further o_rx_valid.
- FSM states: IDLE, SETUP, SHIFT, GAP, HOLD, FINISH.
  - IDLE: on i_start, latch i_addr and i_len, set o_busy=1 next cycle, drive o_cs=0, go to SETUP.
  - SETUP: wait CS_SETUP cycles with o_mosi = bit 7 of the first byte, then go to SHIFT.
  - SHIFT: 8 bits, MSB first.
    - o_mosi is valid before each SCK rising edge.
    - i_miso is sampled in the i_clk cycle where o_sck goes 0->1.
    - o_mosi updates on SCK falling edges.
    - Each bit takes 2*CLK_DIV i_clk cycles.
    - After the 8th falling edge: if more bytes remain, go to GAP (or straight to the next byte's SHIFT when SPI_GAP_EN is undefined); otherwise go to HOLD.
  - GAP: GAP_CYCLES idle cycles, o_sck=0, then SHIFT.
  - HOLD: CS_HOLD cycles, then o_cs=1 and go to FINISH.
  - FINISH: o_done=1 and o_busy=0 in the same cycle, then IDLE. A new i_start is accepted in the next cycle at the earliest.
- Byte sequence on MOSI: addr[15:8], addr[7:0], then i_len bytes of 8'h00.
- Receive path:
  - MISO bytes received during the two address bytes are discarded.
  - Each data byte raises o_rx_valid for exactly one cycle, on the cycle after its 8th sampling edge.
  - o_rx_byte holds its value until the next strobe.
- i_len=0: address-only transaction (16 SCK pulses), then o_done with no o_rx_valid.
- i_len=255: 257 bytes total. The 8-bit remaining-byte counter must not wrap or terminate early.
- i_start while o_busy: ignored, with no effect on the latched address or length.
- Total SCK pulses = 8*(2+i_len). o_sck never toggles while o_cs=1.

Optional Feature:
- Macro: SPI_GAP_EN.
- Defined: the GAP state inserts GAP_CYCLES between consecutive bytes. This lets the slave FSM assert tx_ready and load the memory byte.
- Undefined: bytes are back-to-back, the GAP state is not synthesised, and GAP_CYCLES is ignored.

Decomposition:
- Shared package/header: state encoding constants (3-bit) and the dummy byte value 8'h00. The address byte count (2) also lives there, so the slave-side FSM and this master agree on it.
- One natural sub-module: spi_master_shifter.
  - Handles the SCK divider and 8-bit shift/sample for a single byte.
  - Interface: load byte in, busy/done out, received byte out.
  - The top FSM sequences bytes and controls CS.

Test Plan:
- Reset then idle -> o_cs=1, o_sck=0, no strobes for 100 cycles.
- Start addr=16'hA55A, len=3, slave model returns 8'h11, 8'h22, 8'h33 -> MOSI shows A5,5A,00,00,00. Exactly three o_rx_valid strobes with 11,22,33. Then o_done; 40 SCK pulses.
- Start len=0, addr=16'h8000 -> 16 SCK pulses, no o_rx_valid, o_done once, o_cs high after CS_HOLD.
- i_start pulsed again mid-transfer with addr=16'h1234 -> ignored; MOSI continues the original bytes.
- i_rst asserted during the 2nd data byte -> o_cs=1 and o_sck=0 immediately, no o_done. A following start of len=1 completes normally.
- With SPI_GAP_EN, CLK_DIV=2, GAP_CYCLES=8 -> ≥8 idle i_clk cycles with o_cs=0 and o_sck=0 between every byte. Without the macro, there is no gap between bytes.
